ov7670_stream_emulator: RTL

Generates a synthetic OV7670-style pixel stream (PCLK, HREF, VSYNC, 8-bit RGB565 bytes) from the FPGA clock. It is the transmit end of the camera bus that the down-sampler receives. It drives the down-sampler/M9K/VGA path with known images so that path can be brought up without the camera. It is instantiated in place of the GPIO_1 camera inputs under a build switch.

---
 rtl/ov7670_emu_pkg.sv | 34 +++
 rtl/ov7670_emu_pattern.sv | 28 ++
 rtl/ov7670_stream_emulator.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ov7670_emu_pkg.sv
// ov7670_emu_pkg: shared state encoding, RGB565 colours and pattern selects
// for the OV7670 stream emulator.
package ov7670_emu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VFRONT
    } state_e;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    // Index 0 (leftmost bar) is the rightmost element of the concatenation.
    localparam logic [7:0][15:0] BAR_COLOURS = {
        RGB_BLACK, RGB_BLUE, RGB_RED, RGB_MAGENTA,
        RGB_GREEN, RGB_CYAN, RGB_YELLOW, RGB_WHITE
    };

    localparam logic [1:0] SEL_RED   = 2'd0;
    localparam logic [1:0] SEL_GREEN = 2'd1;
    localparam logic [1:0] SEL_BLUE  = 2'd2;
    localparam logic [1:0] SEL_BARS  = 2'd3;

endpackage

// File: rtl/ov7670_emu_pattern.sv
// ov7670_emu_pattern: maps pixel column, pattern select and scroll offset to
// an RGB565 colour; purely combinational image content.
module ov7670_emu_pattern
    import ov7670_emu_pkg::*;
#(
    parameter int WIDTH = 176,
    localparam int XW = $clog2(WIDTH)
) (
    input  logic [XW-1:0] x_i,
    input  logic [1:0]    sel_i,
    input  logic [XW-1:0] offset_i,
    output logic [15:0]   colour_o
);

    logic [XW:0]   sum;
    logic [XW-1:0] xs;
    logic [2:0]    bar;

    always_comb begin
        sum      = {1'b0, x_i} + {1'b0, offset_i};
        xs       = (sum >= (XW+1)'(WIDTH)) ? XW'(sum - (XW+1)'(WIDTH)) : sum[XW-1:0];
        bar      = 3'(xs / XW'(WIDTH / 8));
        colour_o = (sel_i == SEL_RED)   ? RGB_RED   :
                   (sel_i == SEL_GREEN) ? RGB_GREEN :
                   (sel_i == SEL_BLUE)  ? RGB_BLUE  : BAR_COLOURS[bar];
    end

endmodule

// File: rtl/ov7670_stream_emulator.sv
// ov7670_stream_emulator: synthetic OV7670 camera bus (PCLK/HREF/VSYNC/DATA).
// Define OV7670_EMU_SCROLL_EN to scroll the colour bars one pixel per frame.
module ov7670_stream_emulator
    import ov7670_emu_pkg::*;
#(
    parameter int WIDTH     = 176,
    parameter int HEIGHT    = 144,
    parameter int VSYNC_LEN = 1568,
    parameter int V_BACK    = 784,
    parameter int H_BLANK   = 144,
    parameter int V_FRONT   = 784
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       EN,
    input  logic [1:0] PATTERN_SEL,
    output logic       PCLK,
    output logic       HREF,
    output logic       VSYNC,
    output logic [7:0] DATA,
    output logic       FRAME_DONE
);

    localparam int LINE_BYTES = 2 * WIDTH;
    localparam int M1 = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
    localparam int M2 = (LINE_BYTES > H_BLANK) ? LINE_BYTES : H_BLANK;
    localparam int M3 = (M1 > M2) ? M1 : M2;
    localparam int MAX_CNT = (M3 > V_FRONT) ? M3 : V_FRONT;
    localparam int CW = $clog2(MAX_CNT);
    localparam int YW = $clog2(HEIGHT);
    localparam int XW = $clog2(WIDTH);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [YW-1:0] y_q, y_d;
    logic [1:0]    sel_q, sel_d;
    logic          pclk_q, done_q, done_d;
    logic [XW-1:0] offset;
    logic [15:0]   colour;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            sel_q   <= '0;
            pclk_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            pclk_q  <= ~pclk_q;
            done_q  <= done_d;
        end
    end

    // Everything but PCLK and FRAME_DONE advances only on the PCLK falling edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        if (pclk_q) begin
            cnt_d = cnt_q + 1'b1;
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (EN) begin
                        state_d = ST_VSYNC;
                        sel_d   = PATTERN_SEL;
                    end
                end
                ST_VSYNC: if (cnt_q == CW'(VSYNC_LEN - 1)) begin
                    state_d = ST_VBACK;
                    cnt_d   = '0;
                end
                ST_VBACK: if (cnt_q == CW'(V_BACK - 1)) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                    y_d     = '0;
                end
                ST_ACTIVE: if (cnt_q == CW'(LINE_BYTES - 1)) begin
                    state_d = ST_HBLANK;
                    cnt_d   = '0;
                end
                ST_HBLANK: if (cnt_q == CW'(H_BLANK - 1)) begin
                    cnt_d = '0;
                    if (y_q == YW'(HEIGHT - 1)) begin
                        state_d = ST_VFRONT;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ACTIVE;
                        y_d     = y_q + 1'b1;
                    end
                end
                ST_VFRONT: if (cnt_q == CW'(V_FRONT - 1)) begin
                    cnt_d   = '0;
                    state_d = EN ? ST_VSYNC : ST_IDLE;
                    sel_d   = PATTERN_SEL;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef OV7670_EMU_SCROLL_EN
    logic [XW-1:0] offset_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            offset_q <= '0;
        else if (done_q)
            offset_q <= (offset_q == XW'(WIDTH - 1)) ? '0 : offset_q + 1'b1;
    end

    assign offset = offset_q;
`else
    assign offset = '0;
`endif

    ov7670_emu_pattern #(.WIDTH(WIDTH)) u_pattern (
        .x_i      (XW'(cnt_q >> 1)),
        .sel_i    (sel_q),
        .offset_i (offset),
        .colour_o (colour)
    );

    assign PCLK       = pclk_q;
    assign HREF       = (state_q == ST_ACTIVE);
    assign VSYNC      = (state_q == ST_VSYNC);
    assign DATA       = HREF ? (cnt_q[0] ? colour[7:0] : colour[15:8]) : 8'h00;
    assign FRAME_DONE = done_q;

endmodule
